// File: rtl/systolic_feeder.sv
// Operand sequencer for the systolic array: buffers X (MxN) and W (NxK), then streams them skewed.
// Optional macro SYSTOLIC_FEEDER_PERF_EN adds a perf_cycles output (start-to-done cycle count).
module systolic_feeder #(
  parameter int M          = 5,
  parameter int N          = 3,
  parameter int K          = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_LAT   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      x_wr_en,
  input  logic [$clog2(M*N)-1:0]    x_wr_addr,
  input  logic [DATA_WIDTH-1:0]     x_wr_data,
  input  logic                      w_wr_en,
  input  logic [$clog2(N*K)-1:0]    w_wr_addr,
  input  logic [DATA_WIDTH-1:0]     w_wr_data,
  input  logic                      start,
  output logic [DATA_WIDTH*M-1:0]   x_out,
  output logic [DATA_WIDTH*K-1:0]   w_out,
  output logic                      feed_valid,
  output logic                      busy,
  output logic                      done
`ifdef SYSTOLIC_FEEDER_PERF_EN
  ,output logic [31:0]              perf_cycles
`endif
);

  // state   | meaning
  // S_IDLE  | buffers writable, waiting for start
  // S_FEED  | streaming skewed operands, cnt = t
  // S_WAIT  | draining the array pipeline, outputs held at 0
  // S_DONE  | one cycle, Y valid at the array output

  localparam int F   = N + ((M > K) ? M : K) - 1;
  localparam int D   = M + K - 2 + PIPE_LAT;
  localparam int CW  = $clog2(((F > D) ? F : D) + 1);
  localparam int XAW = $clog2(M*N);
  localparam int WAW = $clog2(N*K);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH*M-1:0] x_out_q, x_out_d;
  logic [DATA_WIDTH*K-1:0] w_out_q, w_out_d;
  logic [DATA_WIDTH-1:0]   xbuf_q [M*N];
  logic [DATA_WIDTH-1:0]   xbuf_d [M*N];
  logic [DATA_WIDTH-1:0]   wbuf_q [N*K];
  logic [DATA_WIDTH-1:0]   wbuf_d [N*K];

  assign feed_valid = (state_q == S_FEED);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign x_out      = x_out_q;
  assign w_out      = w_out_q;

  always_comb begin
    xbuf_d = xbuf_q;
    wbuf_d = wbuf_q;
    if (x_wr_en && !busy && (int'(x_wr_addr) < M*N)) xbuf_d[x_wr_addr] = x_wr_data;
    if (w_wr_en && !busy && (int'(w_wr_addr) < N*K)) wbuf_d[w_wr_addr] = w_wr_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FEED;
        cnt_d   = '0;
      end
      S_FEED: if (cnt_q == CW'(F-1)) begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_WAIT: if (cnt_q == CW'(D-1)) begin
        state_d = S_DONE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Lanes are built from the post-write buffer so a write accepted with start reaches t=0.
  always_comb begin
    x_out_d = '0;
    w_out_d = '0;
    if (state_d == S_FEED) begin
      for (int i = 0; i < M; i++) begin
        if (int'(cnt_d) >= i && int'(cnt_d) - i < N)
          x_out_d[DATA_WIDTH*i +: DATA_WIDTH] = xbuf_d[XAW'(i*N + int'(cnt_d) - i)];
      end
      for (int j = 0; j < K; j++) begin
        if (int'(cnt_d) >= j && int'(cnt_d) - j < N)
          w_out_d[DATA_WIDTH*j +: DATA_WIDTH] = wbuf_d[WAW'((int'(cnt_d) - j)*K + j)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      x_out_q <= '0;
      w_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_out_q <= x_out_d;
      w_out_q <= w_out_d;
    end
  end

  always_ff @(posedge clk) begin
    xbuf_q <= xbuf_d;
    wbuf_q <= wbuf_d;
  end

`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0] perf_cnt_q, perf_q;

  // Running count covers FEED+WAIT; the DONE cycle itself is added when latching.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      if (state_q == S_IDLE && start)
        perf_cnt_q <= '0;
      else if ((state_q == S_FEED || state_q == S_WAIT) && perf_cnt_q != '1)
        perf_cnt_q <= perf_cnt_q + 1'b1;
      if (state_q == S_DONE)
        perf_q <= (perf_cnt_q == '1) ? '1 : perf_cnt_q + 1'b1;
    end
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: cycle-index reference model plus directed literal checks.
module tb_systolic_feeder;
  localparam int M = 5, N = 3, K = 4, DW = 32, PL = 2;
  localparam int F = N + ((M > K) ? M : K) - 1;
  localparam int D = M + K - 2 + PL;
  localparam int LW = DW * M;

  logic clk, rst, x_wr_en, w_wr_en, start;
  logic [3:0] x_wr_addr, w_wr_addr;
  logic [DW-1:0] x_wr_data, w_wr_data;
  logic [DW*M-1:0] x_out;
  logic [DW*K-1:0] w_out;
  logic feed_valid, busy, done;
`ifdef SYSTOLIC_FEEDER_PERF_EN
  logic [31:0] perf_cycles;
`endif

  systolic_feeder #(.M(M), .N(N), .K(K), .DATA_WIDTH(DW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .start(start), .x_out(x_out), .w_out(w_out),
    .feed_valid(feed_valid), .busy(busy), .done(done)
`ifdef SYSTOLIC_FEEDER_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int phase = 0;                 // cycles since accepted start, 0 = idle
  bit chk_en = 0;
  logic [DW-1:0] Xm [M][N];
  logic [DW-1:0] Wm [N][K];
  logic [DW-1:0] xh [F][M];
  logic [DW-1:0] wh [F][K];
  logic [31:0] perf_exp = 0;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_edge();
    bit was_busy = (phase != 0);
    if (x_wr_en && !was_busy && x_wr_addr < M*N) Xm[x_wr_addr / N][x_wr_addr % N] = x_wr_data;
    if (w_wr_en && !was_busy && w_wr_addr < N*K) Wm[w_wr_addr / K][w_wr_addr % K] = w_wr_data;
    if (rst) begin
      phase = 0;
      perf_exp = 0;
    end else if (phase != 0) begin
      if (phase == F + D + 1) begin
        phase = 0;
        perf_exp = F + D + 1;
      end else phase++;
    end else if (start) phase = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    rst = 0; start = 0; x_wr_en = 0; w_wr_en = 0;
  endtask

  function automatic logic [LW-1:0] exp_x();
    logic [LW-1:0] v = '0;
    if (phase >= 1 && phase <= F)
      for (int i = 0; i < M; i++)
        if (phase - 1 - i >= 0 && phase - 1 - i < N) v[DW*i +: DW] = Xm[i][phase-1-i];
    return v;
  endfunction

  function automatic logic [LW-1:0] exp_w();
    logic [LW-1:0] v = '0;
    if (phase >= 1 && phase <= F)
      for (int j = 0; j < K; j++)
        if (phase - 1 - j >= 0 && phase - 1 - j < N) v[DW*j +: DW] = Wm[phase-1-j][j];
    return v;
  endfunction

  // Array emulation: PE(i,j) multiplies x lane i delayed j steps with w lane j delayed i steps.
  function automatic logic [DW-1:0] array_y(int i, int j);
    logic [DW-1:0] acc = '0;
    for (int s = 0; s < F + M + K; s++)
      if (s - j >= 0 && s - j < F && s - i >= 0 && s - i < F) acc += xh[s-j][i] * wh[s-i][j];
    return acc;
  endfunction

  function automatic logic [DW-1:0] matmul_y(int i, int j);
    logic [DW-1:0] acc = '0;
    for (int n = 0; n < N; n++) acc += Xm[i][n] * Wm[n][j];
    return acc;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("feed_valid", LW'(feed_valid), LW'(phase >= 1 && phase <= F));
      chk("busy", LW'(busy), LW'(phase != 0));
      chk("done", LW'(done), LW'(phase == F + D + 1));
      chk("x_out", LW'(x_out), exp_x());
      chk("w_out", LW'(w_out), exp_w());
`ifdef SYSTOLIC_FEEDER_PERF_EN
      chk("perf_cycles", LW'(perf_cycles), LW'(perf_exp));
`endif
      if (phase >= 1 && phase <= F) begin
        for (int i = 0; i < M; i++) xh[phase-1][i] = x_out[DW*i +: DW];
        for (int j = 0; j < K; j++) wh[phase-1][j] = w_out[DW*j +: DW];
      end
      if (phase == F + D + 1)
        for (int i = 0; i < M; i++)
          for (int j = 0; j < K; j++) chk("y_matmul", LW'(array_y(i, j)), LW'(matmul_y(i, j)));
    end
  end

  initial begin
    int ndone;
    rst = 1; start = 0; x_wr_en = 0; w_wr_en = 0;
    x_wr_addr = 0; w_wr_addr = 0; x_wr_data = 0; w_wr_data = 0;
    tick();
    rst = 1;
    tick();
    chk_en = 1;
    @(negedge clk);
    chk("reset_busy", LW'(busy), 0);
    chk("reset_x", LW'(x_out), 0);

    // Skew pattern
    for (int a = 0; a < M*N; a++) begin
      x_wr_en = 1; x_wr_addr = 4'(a); x_wr_data = 32'(16*(a / N) + a % N);
      if (a < N*K) begin
        w_wr_en = 1; w_wr_addr = 4'(a); w_wr_data = 32'(16*(a / K) + a % K);
      end
      tick();
    end
    x_wr_en = 1; x_wr_addr = 4'd15; x_wr_data = 32'hDEAD;
    w_wr_en = 1; w_wr_addr = 4'd13; w_wr_data = 32'hBEEF;
    tick();

    start = 1;
    tick();
    ndone = 0;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (done) ndone++;
      case (k)
        1: begin
          chk("c1_x", LW'(x_out), 0);
          chk("c1_w", LW'(w_out), 0);
          chk("c1_feed", LW'(feed_valid), 1);
        end
        3: begin
          chk("c3_x", LW'(x_out), {32'h0, 32'h0, 32'h20, 32'h11, 32'h02});
          chk("c3_w", LW'(w_out), LW'({32'h0, 32'h02, 32'h11, 32'h20}));
        end
        7: begin
          chk("c7_x", LW'(x_out), {32'h42, 128'h0});
          chk("c7_w", LW'(w_out), 0);
        end
        8:  chk("c8_feed", LW'(feed_valid), 0);
        17: chk("c17_done", LW'(done), 1);
        18: begin
          chk("c18_busy", LW'(busy), 0);
`ifdef SYSTOLIC_FEEDER_PERF_EN
          chk("perf_17", LW'(perf_cycles), 17);
`endif
        end
        default: ;
      endcase
      if (k == 4) begin x_wr_en = 1; x_wr_addr = 0; x_wr_data = 32'hAA; end
      if (k == 10) start = 1;
      if (k < 18) tick();
    end
    chk("one_done", LW'(ndone), 1);

    // Write during previous FEED must not show up
    start = 1;
    tick();
    @(negedge clk);
    chk("old_x00", LW'(x_out[DW-1:0]), 0);
    repeat (17) tick();
`ifdef SYSTOLIC_FEEDER_PERF_EN
    repeat (3) tick();
    @(negedge clk);
    chk("perf_hold", LW'(perf_cycles), 17);
`endif

    // Write together with start is used by that feed
    x_wr_en = 1; x_wr_addr = 0; x_wr_data = 32'd9; start = 1;
    tick();
    @(negedge clk);
    chk("coll_x00", LW'(x_out[DW-1:0]), 9);
    repeat (17) tick();

    // Reset mid-FEED
    start = 1;
    tick();
    tick(); tick();
    rst = 1;
    tick();
    @(negedge clk);
    chk("rst_busy", LW'(busy), 0);
    chk("rst_x", LW'(x_out), 0);
    chk("rst_w", LW'(w_out), 0);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_no_done", LW'(ndone), 0);

    // End to end: X=1, W=2 -> Y=6
    for (int a = 0; a < M*N; a++) begin
      x_wr_en = 1; x_wr_addr = 4'(a); x_wr_data = 1;
      if (a < N*K) begin w_wr_en = 1; w_wr_addr = 4'(a); w_wr_data = 2; end
      tick();
    end
    start = 1;
    tick();
    repeat (16) tick();
    @(negedge clk);
    chk("e2e_done", LW'(done), 1);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < K; j++) chk("e2e_y", LW'(array_y(i, j)), 6);
    tick();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      x_wr_en = 1'($urandom_range(0, 1)); x_wr_addr = 4'($urandom_range(0, 15)); x_wr_data = $urandom;
      w_wr_en = 1'($urandom_range(0, 1)); w_wr_addr = 4'($urandom_range(0, 15)); w_wr_data = $urandom;
      start = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
